// File: rtl/outport_pkg.sv
// Shared constants for the output-port VC table: geometry, owner-entry layout, credit width.
package outport_pkg;
  localparam int no_inport                   = 6;
  localparam int no_vc                       = 13;
  localparam int floorplusone_log2_no_vc     = 4;
  localparam int buf_depth                   = 4;
  localparam int floorplusone_log2_buf_depth = 3;

  localparam int vc_w    = floorplusone_log2_no_vc;
  localparam int credit_w = floorplusone_log2_buf_depth;
  localparam int entry_w = no_inport + floorplusone_log2_no_vc;

  // Entry layout: {owner inport one-hot, owner input VC}
  localparam int owner_vc_lsb   = 0;
  localparam int owner_vc_msb   = vc_w - 1;
  localparam int owner_port_lsb = vc_w;
  localparam int owner_port_msb = entry_w - 1;
endpackage

// File: rtl/encoder.sv
// One-hot to binary encoder; result is meaningless unless exactly one bit is set.
module encoder #(
  parameter int n = 13,
  parameter int w = 4
) (
  input  logic [n-1:0] onehot,
  output logic [w-1:0] bin
);
  always_comb begin
    bin = '0;
    for (int i = 0; i < n; i++)
      if (onehot[i]) bin = bin | w'(i);
  end
endmodule

// File: rtl/vc_credit_counter.sv
// Per-VC downstream credit counter; resets full, saturates at buf_depth, never wraps below zero.
module vc_credit_counter
  import outport_pkg::*;
(
  input  logic clk,
  input  logic rs_n,
  input  logic inc,
  input  logic dec,
  output logic avail,
  output logic ovf
);
  logic [credit_w-1:0] cnt;

  assign avail = (cnt != '0);
  // A return arriving with the buffer already full is a lost credit upstream.
  assign ovf   = inc && !dec && (cnt == credit_w'(buf_depth));

  always_ff @(posedge clk) begin
    if (!rs_n)
      cnt <= credit_w'(buf_depth);
    else if (inc && !dec && cnt != credit_w'(buf_depth))
      cnt <= cnt + credit_w'(1);
    else if (dec && !inc && cnt != '0)
      cnt <= cnt - credit_w'(1);
  end
endmodule

// File: rtl/outport_vc_table_cr.sv
// Output-port VC ownership table with per-VC credits; registered owner lookup, 1-cycle latency.
// Optional OUTPORT_TABLE_BYPASS_EN: a request may hit an entry being allocated in the same cycle.
module outport_vc_table_cr
  import outport_pkg::*;
(
  input  logic                 clk,
  input  logic                 rs_n,
  input  logic                 alloc_en,
  input  logic [vc_w-1:0]      alloc_addr,
  input  logic [no_inport-1:0] inport_vec,
  input  logic [vc_w-1:0]      invc_no,
  input  logic [no_vc-1:0]     read_addr,
  input  logic                 release_sig,
  input  logic [no_vc-1:0]     credit_in,
  output logic                 called_valid,
  output logic [no_inport-1:0] called_inport_vec,
  output logic [vc_w-1:0]      called_invc_no,
  output logic [no_vc-1:0]     tags,
  output logic [no_vc-1:0]     credit_avail,
  output logic                 err
);
  logic [entry_w-1:0] table_q [no_vc];
  logic [vc_w-1:0]    rd_idx;
  logic [entry_w-1:0] rd_entry, wr_entry;
  logic [no_vc-1:0]   alloc_dec, alloc_wr, rel_vec, dec_vec, cnt_ovf;
  logic rd_any, rd_onehot, rd_multi, tag_hit, byp_hit, grant, alloc_err;

  encoder #(.n(no_vc), .w(vc_w)) u_enc (.onehot(read_addr), .bin(rd_idx));

  assign rd_any    = |read_addr;
  assign rd_onehot = rd_any && ((read_addr & (read_addr - no_vc'(1))) == '0);
  assign rd_multi  = rd_any && !rd_onehot;
  assign tag_hit   = |(read_addr & tags);
`ifdef OUTPORT_TABLE_BYPASS_EN
  assign byp_hit   = |(read_addr & alloc_dec & ~tags);
`else
  assign byp_hit   = 1'b0;
`endif
  assign grant     = rd_onehot && (tag_hit || byp_hit) && |(read_addr & credit_avail);
  assign rel_vec   = (grant && release_sig) ? read_addr : '0;
  assign dec_vec   = grant ? read_addr : '0;
  assign wr_entry  = {inport_vec, invc_no};

  // Out-of-range addresses decode to nothing, so they fall out as errors.
  always_comb begin
    alloc_dec = '0;
    for (int i = 0; i < no_vc; i++)
      alloc_dec[i] = alloc_en && (alloc_addr == vc_w'(i));
  end

  // An entry being released this cycle may be handed straight to a new owner.
  assign alloc_wr  = alloc_dec & (~tags | rel_vec);
  assign alloc_err = alloc_en && (alloc_wr == '0);

  always_comb begin
    rd_entry = '0;
    for (int i = 0; i < no_vc; i++)
      if (rd_idx == vc_w'(i)) rd_entry = table_q[i];
    if (byp_hit) rd_entry = wr_entry;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < no_vc; i++)
      if (alloc_wr[i]) table_q[i] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rs_n) begin
      tags              <= '0;
      called_valid      <= 1'b0;
      called_inport_vec <= '0;
      called_invc_no    <= '0;
      err               <= 1'b0;
    end else begin
      tags              <= (tags & ~rel_vec) | alloc_wr;
      called_valid      <= grant;
      called_inport_vec <= grant ? rd_entry[owner_port_msb:owner_port_lsb] : '0;
      called_invc_no    <= grant ? rd_entry[owner_vc_msb:owner_vc_lsb] : '0;
      err               <= alloc_err || rd_multi || (|cnt_ovf);
    end
  end

  for (genvar g = 0; g < no_vc; g++) begin : g_cnt
    vc_credit_counter u_cnt (
      .clk   (clk),
      .rs_n  (rs_n),
      .inc   (credit_in[g]),
      .dec   (dec_vec[g]),
      .avail (credit_avail[g]),
      .ovf   (cnt_ovf[g])
    );
  end
endmodule

// File: tb/tb_outport_vc_table_cr.sv
// Scoreboarded bench for outport_vc_table_cr: owner responses queued at request time, compared one cycle later.
module tb_outport_vc_table_cr;
  logic        clk = 1'b0;
  logic        rs_n;
  logic        alloc_en;
  logic [3:0]  alloc_addr;
  logic [5:0]  inport_vec;
  logic [3:0]  invc_no;
  logic [12:0] read_addr;
  logic        release_sig;
  logic [12:0] credit_in;
  logic        called_valid;
  logic [5:0]  called_inport_vec;
  logic [3:0]  called_invc_no;
  logic [12:0] tags;
  logic [12:0] credit_avail;
  logic        err;

  typedef struct packed {
    logic       v;
    logic [5:0] p;
    logic [3:0] c;
  } resp_t;

  resp_t sb[$];
  resp_t exp_r, got_r;
  int checks = 0;
  int errors = 0;

  outport_vc_table_cr dut (
    .clk(clk), .rs_n(rs_n), .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .inport_vec(inport_vec), .invc_no(invc_no), .read_addr(read_addr),
    .release_sig(release_sig), .credit_in(credit_in), .called_valid(called_valid),
    .called_inport_vec(called_inport_vec), .called_invc_no(called_invc_no),
    .tags(tags), .credit_avail(credit_avail), .err(err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    alloc_en = 0; alloc_addr = 0; inport_vec = 0; invc_no = 0;
    read_addr = 0; release_sig = 0; credit_in = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic alloc(input logic [3:0] a, input logic [5:0] p, input logic [3:0] c);
    alloc_en = 1; alloc_addr = a; inport_vec = p; invc_no = c;
  endtask

  task automatic test_reset();
    rs_n = 0; idle();
    tick(); tick();
    checks++; if (tags !== 13'h0) begin errors++; $display("FAIL reset_tags got %h exp 0", tags); end
    checks++; if (called_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", called_valid); end
    checks++; if (credit_avail !== 13'h1FFF) begin errors++; $display("FAIL reset_credit got %h exp 1fff", credit_avail); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    rs_n = 1;
  endtask

  task automatic test_alloc_send();
    alloc(4'd3, 6'b000100, 4'd5);
    tick(); idle();
    checks++; if (tags !== 13'h0008) begin errors++; $display("FAIL alloc_tags got %h exp 0008", tags); end
    read_addr = 13'h1 << 3;
    sb.push_back('{1'b1, 6'b000100, 4'd5});
    tick(); idle();
    got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
    checks++; if (got_r !== exp_r) begin errors++; $display("FAIL send_owner got %h exp %h", got_r, exp_r); end
    checks++; if (credit_avail[3] !== 1'b1) begin errors++; $display("FAIL send_credit got %b exp 1", credit_avail[3]); end
  endtask

  task automatic test_credit_exhaust();
    for (int k = 0; k < 3; k++) begin
      read_addr = 13'h1 << 3;
      sb.push_back('{1'b1, 6'b000100, 4'd5});
      tick();
      got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
      checks++; if (got_r !== exp_r) begin errors++; $display("FAIL exhaust_grant%0d got %h exp %h", k, got_r, exp_r); end
    end
    checks++; if (credit_avail[3] !== 1'b0) begin errors++; $display("FAIL exhaust_avail got %b exp 0", credit_avail[3]); end
    sb.push_back('{1'b0, 6'b0, 4'd0});
    tick(); idle();
    got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
    checks++; if (got_r !== exp_r) begin errors++; $display("FAIL exhaust_nogrant got %h exp %h", got_r, exp_r); end
    credit_in = 13'h1 << 3;
    tick(); idle();
    checks++; if (credit_avail[3] !== 1'b1) begin errors++; $display("FAIL credit_return got %b exp 1", credit_avail[3]); end
    read_addr = 13'h1 << 3;
    sb.push_back('{1'b1, 6'b000100, 4'd5});
    tick(); idle();
    got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
    checks++; if (got_r !== exp_r) begin errors++; $display("FAIL regrant got %h exp %h", got_r, exp_r); end
  endtask

  task automatic test_release_realloc();
    credit_in = 13'h1 << 3;
    tick(); idle();
    read_addr = 13'h1 << 3; release_sig = 1;
    alloc(4'd3, 6'b100000, 4'd9);
    sb.push_back('{1'b1, 6'b000100, 4'd5});
    tick(); idle();
    got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
    checks++; if (got_r !== exp_r) begin errors++; $display("FAIL release_tail got %h exp %h", got_r, exp_r); end
    checks++; if (tags[3] !== 1'b1) begin errors++; $display("FAIL realloc_tag got %b exp 1", tags[3]); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL realloc_err got %b exp 0", err); end
    credit_in = 13'h1 << 3;
    tick(); idle();
    read_addr = 13'h1 << 3;
    sb.push_back('{1'b1, 6'b100000, 4'd9});
    tick(); idle();
    got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
    checks++; if (got_r !== exp_r) begin errors++; $display("FAIL new_owner got %h exp %h", got_r, exp_r); end
  endtask

  task automatic test_errors();
    alloc(4'd7, 6'b000001, 4'd1);
    tick(); idle();
    alloc(4'd7, 6'b000010, 4'd2);
    tick(); idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL alloc_tagged_err got %b exp 1", err); end
    tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_pulse got %b exp 0", err); end
    read_addr = 13'h1 << 7;
    sb.push_back('{1'b1, 6'b000001, 4'd1});
    tick(); idle();
    got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
    checks++; if (got_r !== exp_r) begin errors++; $display("FAIL entry_kept got %h exp %h", got_r, exp_r); end
    read_addr = 13'h0005;
    sb.push_back('{1'b0, 6'b0, 4'd0});
    tick(); idle();
    got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
    checks++; if (got_r !== exp_r) begin errors++; $display("FAIL multi_nogrant got %h exp %h", got_r, exp_r); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL multi_err got %b exp 1", err); end
    credit_in = 13'h1;
    tick(); idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", err); end
    alloc(4'd14, 6'b000001, 4'd0);
    tick(); idle();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL range_err got %b exp 1", err); end
    checks++; if (tags !== 13'h0088) begin errors++; $display("FAIL range_tags got %h exp 0088", tags); end
    // Saturated counter must still be exactly 4: avail drops after the 4th grant, not before.
    alloc(4'd0, 6'b010000, 4'd3);
    tick(); idle();
    for (int k = 0; k < 4; k++) begin
      read_addr = 13'h1;
      sb.push_back('{1'b1, 6'b010000, 4'd3});
      tick(); idle();
      got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
      checks++; if (got_r !== exp_r) begin errors++; $display("FAIL sat_grant%0d got %h exp %h", k, got_r, exp_r); end
      checks++; if (credit_avail[0] !== (k < 3)) begin errors++; $display("FAIL sat_avail%0d got %b exp %b", k, credit_avail[0], k < 3); end
    end
  endtask

  task automatic test_bypass();
    alloc(4'd2, 6'b001000, 4'd7);
    read_addr = 13'h1 << 2;
`ifdef OUTPORT_TABLE_BYPASS_EN
    sb.push_back('{1'b1, 6'b001000, 4'd7});
`else
    sb.push_back('{1'b0, 6'b0, 4'd0});
`endif
    tick(); idle();
    got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
    checks++; if (got_r !== exp_r) begin errors++; $display("FAIL bypass got %h exp %h", got_r, exp_r); end
    checks++; if (tags[2] !== 1'b1) begin errors++; $display("FAIL bypass_tag got %b exp 1", tags[2]); end
    read_addr = 13'h1 << 2;
    sb.push_back('{1'b1, 6'b001000, 4'd7});
    tick(); idle();
    got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
    checks++; if (got_r !== exp_r) begin errors++; $display("FAIL bypass_retry got %h exp %h", got_r, exp_r); end
  endtask

  task automatic test_reset_mid();
    read_addr = 13'h1 << 7; alloc(4'd5, 6'b000010, 4'd4); rs_n = 0;
    sb.push_back('{1'b0, 6'b0, 4'd0});
    tick(); idle(); rs_n = 1;
    got_r = {called_valid, called_inport_vec, called_invc_no}; exp_r = sb.pop_front();
    checks++; if (got_r !== exp_r) begin errors++; $display("FAIL midrst_resp got %h exp %h", got_r, exp_r); end
    checks++; if (tags !== 13'h0) begin errors++; $display("FAIL midrst_tags got %h exp 0", tags); end
    checks++; if (credit_avail !== 13'h1FFF) begin errors++; $display("FAIL midrst_credit got %h exp 1fff", credit_avail); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err got %b exp 0", err); end
  endtask

  initial begin
    test_reset();
    test_alloc_send();
    test_credit_exhaust();
    test_release_realloc();
    test_errors();
    test_bypass();
    test_reset_mid();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
